// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the image-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEFAULT_MAX_BURST = 16;

    typedef enum logic [1:0] {
        IDLE,
        OWN_RD,
        OWN_WR
    } state_t;

    typedef enum logic {
        RD,
        WR
    } owner_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Beat and contention counters for mem_port_arbiter (built only with ARB_PERF_CNT_EN).
module arb_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_beat,
    input  logic        wr_beat,
    input  logic        conflict,
    output logic [31:0] rd_beats,
    output logic [31:0] wr_beats,
    output logic [31:0] conflict_cycles
);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_beats        <= '0;
            wr_beats        <= '0;
            conflict_cycles <= '0;
        end else begin
            if (rd_beat)  rd_beats        <= rd_beats + 32'd1;
            if (wr_beat)  wr_beats        <= wr_beats + 32'd1;
            if (conflict) conflict_cycles <= conflict_cycles + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, burst-capped arbiter for the shared image-memory port (read vs writeback).
// Optional perf counters: define ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_rw,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_data_in
`ifdef ARB_PERF_CNT_EN
   ,output logic [31:0]       rd_beats,
    output logic [31:0]       wr_beats,
    output logic [31:0]       conflict_cycles
`endif
);

    localparam int unsigned          CNT_W   = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]     CNT_CAP = CNT_W'(MAX_BURST - 1);

    state_t            state, state_nx;
    owner_t            last_owner, last_owner_nx;
    logic [CNT_W-1:0]  burst_cnt, burst_cnt_nx;
    logic              own_req, other_req;
    logic              rd_beat, wr_beat;

    always_comb begin
        state_nx      = state;
        last_owner_nx = last_owner;
        burst_cnt_nx  = burst_cnt;
        own_req       = 1'b0;
        other_req     = 1'b0;

        unique case (state)
            IDLE: begin
                if (rd_req && wr_req)
                    state_nx = (last_owner == WR) ? OWN_RD : OWN_WR;
                else if (rd_req)
                    state_nx = OWN_RD;
                else if (wr_req)
                    state_nx = OWN_WR;
            end
            OWN_RD: begin
                own_req   = rd_req;
                other_req = wr_req;
            end
            OWN_WR: begin
                own_req   = wr_req;
                other_req = rd_req;
            end
            default: state_nx = IDLE;
        endcase

        // own_req is true in the cap test, so the cap only fires on an accepted beat
        if (state == OWN_RD || state == OWN_WR) begin
            if (!own_req || (burst_cnt == CNT_CAP && other_req)) begin
                last_owner_nx = (state == OWN_RD) ? RD : WR;
                burst_cnt_nx  = '0;
                if (other_req)
                    state_nx = (state == OWN_RD) ? OWN_WR : OWN_RD;
                else
                    state_nx = IDLE;
            end else if (burst_cnt != CNT_CAP) begin
                burst_cnt_nx = burst_cnt + CNT_W'(1);
            end
        end
    end

    assign rd_gnt       = (state == OWN_RD);
    assign wr_gnt       = (state == OWN_WR);
    assign rd_beat      = rd_gnt && rd_req;
    assign wr_beat      = wr_gnt && wr_req;
    assign mem_en       = own_req;
    assign mem_rw       = wr_gnt;
    assign mem_addr     = rd_beat ? rd_addr : (wr_beat ? wr_addr : '0);
    assign mem_data_out = wr_beat ? wr_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= WR;
            burst_cnt  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            state      <= state_nx;
            last_owner <= last_owner_nx;
            burst_cnt  <= burst_cnt_nx;
            rd_valid   <= rd_beat;
            rd_data    <= rd_beat ? mem_data_in : '0;
        end
    end

`ifdef ARB_PERF_CNT_EN
    arb_perf_counters u_perf (
        .clk             (clk),
        .reset           (reset),
        .rd_beat         (rd_beat),
        .wr_beat         (wr_beat),
        .conflict        (rd_req && wr_req && !(rd_gnt && wr_gnt)),
        .rd_beats        (rd_beats),
        .wr_beats        (wr_beats),
        .conflict_cycles (conflict_cycles)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: driver pushes expected accesses, monitor pops them.
module tb_mem_port_arbiter;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b1, wr_req = 1'b1;
    logic [31:0] rd_addr = '0, wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        rd_gnt, wr_gnt, rd_valid, mem_rw, mem_en;
    logic [7:0]  rd_data, mem_data_out, mem_data_in;
    logic [31:0] mem_addr;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] rd_beats, wr_beats, conflict_cycles;
`endif

    always #5 clk = ~clk;

    // memory answers combinationally from the address
    assign mem_data_in = 8'hA0 + mem_addr[7:0];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(8), .MAX_BURST(MAXB)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_rw       (mem_rw),
        .mem_en       (mem_en),
        .mem_data_in  (mem_data_in)
`ifdef ARB_PERF_CNT_EN
       ,.rd_beats        (rd_beats),
        .wr_beats        (wr_beats),
        .conflict_cycles (conflict_cycles)
`endif
    );

    typedef struct {
        int          cyc;
        bit          rw;
        logic [31:0] addr;
        logic [7:0]  data;
    } mem_exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rd_exp_t;

    mem_exp_t mem_q[$];
    rd_exp_t  rd_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit done = 1'b0;

    // reference model: owner 0=none 1=read 2=write, beats counted without saturation
    int owner = 0;
    int last = 2;
    int nbeat = 0;
    int unsigned m_rd = 0, m_wr = 0, m_conf = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit rr, input logic [31:0] ra,
                        input bit ww, input logic [31:0] wa, input logic [7:0] wd);
        bit rb, wb, mine, other;
        @(negedge clk);
        cyc++;
        check("rd_gnt", 64'(rd_gnt), 64'(owner == 1));
        check("wr_gnt", 64'(wr_gnt), 64'(owner == 2));
`ifdef ARB_PERF_CNT_EN
        check("rd_beats", 64'(rd_beats), 64'(m_rd));
        check("wr_beats", 64'(wr_beats), 64'(m_wr));
        check("conflict_cycles", 64'(conflict_cycles), 64'(m_conf));
`endif
        reset   = rst;
        rd_req  = rr;
        rd_addr = ra;
        wr_req  = ww;
        wr_addr = wa;
        wr_data = wd;

        rb = (owner == 1) && rr;
        wb = (owner == 2) && ww;
        if (rb) mem_q.push_back('{cyc, 1'b0, ra, 8'h00});
        if (wb) mem_q.push_back('{cyc, 1'b1, wa, wd});
        if (rb && !rst) rd_q.push_back('{cyc + 1, 8'hA0 + ra[7:0]});

        if (rst) begin
            m_rd = 0; m_wr = 0; m_conf = 0;
        end else begin
            m_rd   += rb ? 1 : 0;
            m_wr   += wb ? 1 : 0;
            m_conf += (rr && ww) ? 1 : 0;
        end

        if (rst) begin
            owner = 0; last = 2; nbeat = 0;
        end else if (owner == 0) begin
            if (rr && ww)  owner = (last == 2) ? 1 : 2;
            else if (rr)   owner = 1;
            else if (ww)   owner = 2;
        end else begin
            mine  = (owner == 1) ? rr : ww;
            other = (owner == 1) ? ww : rr;
            if (mine) nbeat++;
            if (!mine || (nbeat >= MAXB && other)) begin
                last  = owner;
                nbeat = 0;
                owner = other ? 3 - owner : 0;
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (cyc > 0 && !done) begin
            bit exp_en, exp_v;
            mem_exp_t me;
            rd_exp_t  re;
            exp_en = (mem_q.size() > 0) && (mem_q[0].cyc == cyc);
            check("mem_en", 64'(mem_en), 64'(exp_en));
            if (exp_en) begin
                me = mem_q.pop_front();
                if (mem_en) begin
                    check("mem_addr", 64'(mem_addr), 64'(me.addr));
                    check("mem_rw", 64'(mem_rw), 64'(me.rw));
                    check("mem_data_out", 64'(mem_data_out), 64'(me.data));
                end
            end else if (!mem_en) begin
                check("mem_idle_bus", 64'({mem_addr, mem_data_out}), 64'(0));
            end
            exp_v = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            check("rd_valid", 64'(rd_valid), 64'(exp_v));
            if (exp_v) begin
                re = rd_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(re.data));
            end else begin
                check("rd_data_idle", 64'(rd_data), 64'(0));
            end
        end
    end

    initial begin
        int p_rd, p_wr;
        int probs[4] = '{0, 30, 70, 100};

        // reset held with both requesting, then sustained contention
        for (int i = 0; i < 3; i++) step(1, 1, 32'h0, 1, 32'h0, 8'h00);
        for (int i = 0; i < 70; i++)
            step(0, 1, 32'h100 + i, 1, 32'h200 + i, 8'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 32'h0, 8'h00);

        // read-only: grant cycle then four beats at 0..3
        step(0, 1, 32'h0, 0, 32'h0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 1, i, 0, 32'h0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 32'h0, 8'h00);

        // write-only long burst, no cap without contention
        step(0, 0, 32'h0, 1, 32'h0010_0000, 8'h00);
        for (int i = 0; i < 40; i++)
            step(0, 0, 32'h0, 1, 32'h0010_0000 + i, 8'(8'h30 + i));
        // reader arrives after the saturated burst: next write beat hands over
        for (int i = 0; i < 4; i++)
            step(0, 1, 32'h40 + i, 1, 32'h0010_0100 + i, 8'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 32'h0, 8'h00);

        // reset while a read beat is in flight
        for (int i = 0; i < 5; i++) step(0, 1, 32'h80 + i, 0, 32'h0, 8'h00);
        step(1, 1, 32'h85, 0, 32'h0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 32'h0, 8'h00);

        // randomized traffic with shifting request densities and rare resets
        p_rd = 70; p_wr = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                p_rd = probs[$urandom_range(0, 3)];
                p_wr = probs[$urandom_range(0, 3)];
            end
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < p_rd, $urandom,
                 $urandom_range(0, 99) < p_wr, $urandom, 8'($urandom));
        end

        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 32'h0, 8'h00);
        @(negedge clk);
        #4;
        done = 1'b1;
        check("mem_q_drained", 64'(mem_q.size()), 64'(0));
        check("rd_q_drained", 64'(rd_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
